// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - rv32i multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB
// Gates datapath write enables by phase, waits on memory acks, traps illegal ops and timeouts.
module core_sequencer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [6:0] opcode,
  input  logic       reg_write_control,
  input  logic       data_mem_write_control,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_we,
  output logic       rf_we,
  output logic       pc_we,
  output logic       instret,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  localparam logic [6:0] OP_ALU_I  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            opcode_legal;
  logic            opcode_mem;
  logic            cnt_expired;

  always_comb begin
    opcode_legal = (opcode == OP_ALU_I) || (opcode == OP_LOAD) || (opcode == OP_STORE) ||
                   (opcode == OP_BRANCH) || (opcode == OP_JAL);
    opcode_mem   = (opcode == OP_LOAD) || (opcode == OP_STORE);
    cnt_expired  = (cnt_q == CNT_LAST);
  end

  // cnt_q is zero in every state except FETCH/MEM, so each entry starts the wait from zero.
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_we    = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    instret  = 1'b0;
    fault    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (cnt_expired) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      S_DECODE: begin
        state_d = opcode_legal ? S_EXEC : S_FAULT;
      end
      S_EXEC: begin
        state_d = opcode_mem ? S_MEM : S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = data_mem_write_control;
        if (dmem_ack) begin
          state_d = S_WB;
        end else if (cnt_expired) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      S_WB: begin
        rf_we   = reg_write_control;
        pc_we   = 1'b1;
        instret = 1'b1;
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - directed self-checking bench for core_sequencer
module tb_core_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [6:0] opcode;
  logic       reg_write_control;
  logic       data_mem_write_control;
  logic       imem_ack;
  logic       dmem_ack;
  logic       imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we, instret, fault;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  core_sequencer #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .run                    (run),
    .opcode                 (opcode),
    .reg_write_control      (reg_write_control),
    .data_mem_write_control (data_mem_write_control),
    .imem_ack               (imem_ack),
    .dmem_ack               (dmem_ack),
    .imem_req               (imem_req),
    .dmem_req               (dmem_req),
    .dmem_we                (dmem_we),
    .ir_we                  (ir_we),
    .rf_we                  (rf_we),
    .pc_we                  (pc_we),
    .instret                (instret),
    .fault                  (fault),
    .state                  (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // flags order: imem_req dmem_req dmem_we ir_we rf_we pc_we instret fault
  task automatic expect_cyc(input string tag, input logic [2:0] st, input logic [7:0] flags);
    check(tag, {21'd0, state, imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we, instret, fault},
          {21'd0, st, flags});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #4;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    run = 1'b0;
    opcode = 7'd0;
    reg_write_control = 1'b0;
    data_mem_write_control = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    #12;
    expect_cyc("reset", 3'd0, 8'b0000_0000);
    rst_n = 1'b1;
    tick();
    expect_cyc("idle_hold", 3'd0, 8'b0000_0000);

    // ADDI, acks tied high
    opcode = 7'b0010011; reg_write_control = 1'b1;
    imem_ack = 1'b1; dmem_ack = 1'b1; run = 1'b1;
    tick(); expect_cyc("addi_fetch", 3'd1, 8'b1001_0000);
    tick(); expect_cyc("addi_decode", 3'd2, 8'b0000_0000);
    tick(); expect_cyc("addi_exec", 3'd3, 8'b0000_0000);
    tick(); expect_cyc("addi_wb", 3'd5, 8'b0000_1110);
    tick(); expect_cyc("addi_refetch", 3'd1, 8'b1001_0000);

    // LW with dmem_ack delayed 3 cycles
    opcode = 7'b0000011; dmem_ack = 1'b0;
    tick(); expect_cyc("lw_decode", 3'd2, 8'b0000_0000);
    tick(); expect_cyc("lw_exec", 3'd3, 8'b0000_0000);
    tick(); expect_cyc("lw_mem1", 3'd4, 8'b0100_0000);
    tick(); expect_cyc("lw_mem2", 3'd4, 8'b0100_0000);
    tick(); expect_cyc("lw_mem3", 3'd4, 8'b0100_0000);
    tick(); expect_cyc("lw_mem4", 3'd4, 8'b0100_0000);
    dmem_ack = 1'b1;
    tick(); expect_cyc("lw_wb", 3'd5, 8'b0000_1110);
    tick(); expect_cyc("lw_refetch", 3'd1, 8'b1001_0000);

    // SW: store write, no rd write
    opcode = 7'b0100011; reg_write_control = 1'b0; data_mem_write_control = 1'b1;
    tick(); expect_cyc("sw_decode", 3'd2, 8'b0000_0000);
    tick(); expect_cyc("sw_exec", 3'd3, 8'b0000_0000);
    tick(); expect_cyc("sw_mem", 3'd4, 8'b0110_0000);
    tick(); expect_cyc("sw_wb", 3'd5, 8'b0000_0110);
    tick(); expect_cyc("sw_refetch", 3'd1, 8'b1001_0000);

    // BEQ then park in IDLE with run low at WB
    opcode = 7'b1100011; data_mem_write_control = 1'b1;
    tick(); expect_cyc("beq_decode", 3'd2, 8'b0000_0000);
    tick(); expect_cyc("beq_exec", 3'd3, 8'b0000_0000);
    run = 1'b0;
    tick(); expect_cyc("beq_wb", 3'd5, 8'b0000_0110);
    tick(); expect_cyc("park_idle1", 3'd0, 8'b0000_0000);
    tick(); expect_cyc("park_idle2", 3'd0, 8'b0000_0000);

    // fetch timeout with MEM_TIMEOUT=4
    imem_ack = 1'b0; run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); expect_cyc("to_fetch", 3'd1, 8'b1000_0000);
    end
    tick(); expect_cyc("to_fault", 3'd6, 8'b0000_0001);
    do_reset();
    expect_cyc("to_reset", 3'd0, 8'b0000_0000);

    // ack on 4th fetch cycle wins over expiry
    opcode = 7'b1101111;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_cyc("late_fetch", 3'd1, 8'b1000_0000);
    end
    tick();
    imem_ack = 1'b1;
    #1;
    expect_cyc("late_ack", 3'd1, 8'b1001_0000);
    opcode = 7'b0110111;
    tick(); expect_cyc("lui_decode", 3'd2, 8'b0000_0000);

    // unsupported opcode: sticky fault
    for (int i = 0; i < 100; i++) begin
      tick(); expect_cyc("fault_hold", 3'd6, 8'b0000_0001);
    end

    // async reset mid-MEM
    do_reset();
    opcode = 7'b0000011; reg_write_control = 1'b1; data_mem_write_control = 1'b0;
    dmem_ack = 1'b0;
    tick(); expect_cyc("mr_fetch", 3'd1, 8'b1001_0000);
    tick(); expect_cyc("mr_decode", 3'd2, 8'b0000_0000);
    tick(); expect_cyc("mr_exec", 3'd3, 8'b0000_0000);
    tick(); expect_cyc("mr_mem", 3'd4, 8'b0100_0000);
    #2;
    rst_n = 1'b0;
    #1;
    expect_cyc("mr_async", 3'd0, 8'b0000_0000);
    run = 1'b0;
    #3;
    rst_n = 1'b1;
    tick(); expect_cyc("mr_idle", 3'd0, 8'b0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
